rr_decoder_arbiter: RTL
=======================

# rr_decoder_arbiter

Round-robin scheduler that shares one 3-to-8 decoder among eight requesters. It chooses one requester at a time, drives the decoder's 3-bit select, and presents the decoded one-hot grant. A grant lasts until the owner signals done, withdraws its request, or a programmable hold limit expires. It sits between the requester agents and the decode fabric.

## Interface
Parameters:
- N_REQ, 8, number of requesters; fixed to 2**SEL_W.
- SEL_W, 3, select width fed to the decoder.
- HOLD_W, 4, width of the hold-limit input and the internal cycle counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  N_REQ  request vector; bit i high means requester i wants the decoder.
- done  input  1  owner-release strobe; sampled only in GRANT.
- hold_max  input  HOLD_W  maximum grant length in cycles; 0 means no limit; sampled on entry to GRANT.
- sel  output  SEL_W  registered index of the current or last winner; drives the decoder.
- grant_valid  output  1  registered; high while a grant is active.
- gnt  output  N_REQ  one-hot grant: decode(sel) gated by grant_valid; all zeros otherwise.
- busy  output  1  equals grant_valid; kept for status muxing.
- timeout  output  1  registered one-cycle pulse when a grant ends because of hold_max.

## Operation
- **States:** IDLE and GRANT. An internal round-robin pointer `ptr` has SEL_W bits.
- **IDLE:**
  - If req is nonzero at an edge, pick the first set bit searching ptr, ptr+1, … ptr+7, modulo 8 with wrap-around.
  - Load sel with the winner, set grant_valid, clear cnt, latch hold_max into hold_r, and go to GRANT.
  - If req is zero, stay in IDLE; sel holds its value.
- **GRANT:** each edge checks the release conditions in this priority:
  - done = 1.
  - req[sel] = 0.
  - hold_r ≠ 0 and cnt == hold_r − 1; this is the only case that pulses timeout.
- **On release:**
  - ptr ← sel + 1 modulo 8, so 7 wraps to 0.
  - grant_valid ← 0; state ← IDLE.
  - Otherwise cnt increments; it saturates at its all-ones value.
- **Simultaneous events:** done together with the timeout condition counts as a done release, so timeout stays 0. Changes to req[i] for i ≠ sel have no effect during GRANT.
- **Reset:** reset (rst_n low at an edge) forces IDLE and sets ptr=0, sel=0, grant_valid=0, gnt=0, busy=0, timeout=0, cnt=0, hold_r=0. This applies in any state, including mid-grant; the grant drops on the following cycle.

## Timing
- **Request to grant:** req seen at edge k gives gnt and grant_valid high in the cycle after edge k (latency 1).
- **Grant length:** a grant that ends by timeout is high for exactly hold_r cycles.
- **Release:**
  - Release at edge m drops gnt in the cycle after edge m.
  - timeout is high in that same cycle only.
  - IDLE lasts at least one cycle, so back-to-back grants are separated by exactly one dead cycle.
- **Output glitches:** gnt is combinational from registered sel and grant_valid only, so it does not glitch on req.
- **Fairness:** with all eight requesters continuously requesting and hold_max=1, grants rotate 0,1,…,7,0 with a period of 16 cycles.

## Structure
- **Package `decoder_pkg`:** holds the N_REQ, SEL_W and HOLD_W defaults, the state encoding (IDLE=1'b0, GRANT=1'b1), and a function `rr_pick(req, ptr)` that returns the winner index.
- **Sub-module:** one instance of the team's existing decoder3to8 produces decode(sel); its outputs are ANDed with grant_valid.
- **Wrapper and test bench:** no other hierarchy. The bench drives inputs at #10 steps, as the team's existing decoder benches do.

## Test plan
- Reset, then req=8'h00 for 5 cycles: gnt=0, grant_valid=0 and sel=0 throughout.
- req=8'h24, hold_max=0, done pulsed after 3 grant cycles: grant goes to 2 (gnt=8'h04) for 3 cycles, one dead cycle follows, then 5 is granted (gnt=8'h20) with ptr=3 at that point.
- req=8'hFF, hold_max=1, held for 20 cycles: sequence 0,1,2,…,7,0,1; timeout pulses after every grant; the wrap from 7 to 0 is checked.
- req=8'h80, hold_max=4: gnt=8'h80 for exactly 4 cycles, timeout high in the following cycle, then the grant to 7 repeats.
- Grant 3 with hold_max=2, and done asserted at the timeout edge: a done release occurs and timeout stays 0.
- rst_n low for one edge in the middle of a grant to 6: gnt=0 next cycle, ptr=0, and the next arbitration with req=8'h41 grants 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the round-robin decoder arbiter: default sizes,
// FSM state encoding and the rotating-priority winner search.
package decoder_pkg;

  localparam int DEF_N_REQ  = 8;
  localparam int DEF_SEL_W  = 3;
  localparam int DEF_HOLD_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set bit of req scanning ptr, ptr+1, ... with wrap-around. Scanning
  // from the far end downward lets the closest hit overwrite earlier ones.
  function automatic logic [DEF_SEL_W-1:0] rr_pick(
    input logic [DEF_N_REQ-1:0] req,
    input logic [DEF_SEL_W-1:0] ptr
  );
    logic [DEF_SEL_W-1:0] idx;
    logic [DEF_SEL_W-1:0] win;
    win = ptr;
    for (int i = DEF_N_REQ - 1; i >= 0; i--) begin
      idx = ptr + DEF_SEL_W'(i);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

endpackage

// File: rtl/decoder3to8.sv
// Plain 3-to-8 one-hot decoder shared by the requesters.
module decoder3to8 (
  input  logic [2:0] sel,
  output logic [7:0] dec
);

  always_comb begin
    dec = 8'b0000_0001 << sel;
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin owner selection for a single shared 3-to-8 decoder; a grant
// ends on done, on withdrawal of the owner's request, or at the hold limit.
module rr_decoder_arbiter
  import decoder_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              done,
  input  logic [HOLD_W-1:0] hold_max,
  output logic [SEL_W-1:0]  sel,
  output logic              grant_valid,
  output logic [N_REQ-1:0]  gnt,
  output logic              busy,
  output logic              timeout
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              grant_valid_q, grant_valid_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  logic              owner_req;
  logic              hold_hit;
  logic [N_REQ-1:0]  dec;

  assign owner_req = req[sel_q];
  assign hold_hit  = (hold_q != '0) && (cnt_q == hold_q - HOLD_W'(1));

  // NOTE: every variable gets its hold value before the case, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    grant_valid_d = grant_valid_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d         = rr_pick(req, ptr_q);
          grant_valid_d = 1'b1;
          cnt_d         = '0;
          hold_d        = hold_max;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (done || !owner_req || hold_hit) begin
          ptr_d         = sel_q + SEL_W'(1);
          grant_valid_d = 1'b0;
          state_d       = IDLE;
          // Only a pure hold-limit release reports timeout; done wins ties.
          timeout_d     = !done && owner_req;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      sel_q         <= '0;
      grant_valid_q <= 1'b0;
      cnt_q         <= '0;
      hold_q        <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      grant_valid_q <= grant_valid_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      timeout_q     <= timeout_d;
    end
  end

  decoder3to8 u_dec (
    .sel (sel_q),
    .dec (dec)
  );

  assign sel         = sel_q;
  assign grant_valid = grant_valid_q;
  assign busy        = grant_valid_q;
  assign timeout     = timeout_q;
  assign gnt         = dec & {N_REQ{grant_valid_q}};

endmodule
